// File: rtl/briey_prog_loader.sv
// Bulk program loader for the Briey RAM.
// Copies num_lines 64 B lines from host memory (AXI-MM read, one beat per
// burst, one read outstanding) into the core RAM reload port (aw/w, full
// strobe). Holds the core in reset with RAM reload enabled while copying.
//
// Ports:
//   axi4_mm_clk / axi4_mm_rst_n : clock, async active-low reset
//   start, src_base, dst_base, num_lines : transfer request and config
//   busy, done, err, lines_done          : status
//   core_rst, load_en                    : core reset hold / RAM reload enable
//   ar* / r*                             : AXI-MM read master
//   ld_aw_* / ld_w_*                     : RAM load port
//   cksum (PROG_LOADER_CKSUM_EN only)    : XOR of all 32-bit words written
//
// Optional feature macro: PROG_LOADER_CKSUM_EN
module briey_prog_loader #(
  parameter int unsigned RAM_AW = 15,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned LEN_W  = 10,
  parameter logic [11:0] AR_ID  = 12'h0A5
) (
  input  logic                  axi4_mm_clk,
  input  logic                  axi4_mm_rst_n,
  input  logic                  start,
  input  logic [63:0]           src_base,
  input  logic [RAM_AW-1:0]     dst_base,
  input  logic [LEN_W-1:0]      num_lines,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_W-1:0]      lines_done,
  output logic                  core_rst,
  output logic                  load_en,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [63:0]           araddr,
  output logic [11:0]           arid,
  output logic [9:0]            arlen,
  output logic [2:0]            arsize,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  output logic                  ld_aw_valid,
  input  logic                  ld_aw_ready,
  output logic [RAM_AW-1:0]     ld_aw_addr,
  output logic                  ld_w_valid,
  input  logic                  ld_w_ready,
  output logic [DATA_W-1:0]     ld_w_data,
  output logic [DATA_W/8-1:0]   ld_w_strb
`ifdef PROG_LOADER_CKSUM_EN
  ,
  output logic [31:0]           cksum
`endif
);

  localparam int unsigned LINE_SH = 6;
  localparam int unsigned OFS_W   = LEN_W + LINE_SH;
  localparam int unsigned NWORDS  = DATA_W / 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [63:0]         src_q;
  logic [RAM_AW-1:0]   dst_q;
  logic [LEN_W-1:0]    num_q;
  logic [LEN_W-1:0]    lines_q;
  logic [DATA_W-1:0]   buf_q;
  logic                err_q;
  logic                hold_q;
  logic                aw_done_q;
  logic                w_done_q;

  logic                accept_c;
  logic                wr_fin_c;
  logic [LEN_W-1:0]    lines_inc_c;
  logic [OFS_W-1:0]    line_ofs_c;
  logic                unused_rlast_c;

  // rlast carries no information with single-beat bursts
  assign unused_rlast_c = rlast;

  assign accept_c    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // a line completes once both aw and w have handshaken, in any order
  assign wr_fin_c    = (state_q == S_WR) && (aw_done_q || ld_aw_ready) &&
                       (w_done_q || ld_w_ready);
  assign lines_inc_c = lines_q + LEN_W'(1);
  assign line_ofs_c  = {lines_q, {LINE_SH{1'b0}}};

  // State register
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (num_lines == '0) ? S_DONE : S_AR;
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) state_d = (rresp != 2'b00) ? S_DONE : S_WR;
      end
      S_WR: begin
        if (wr_fin_c) state_d = (lines_inc_c == num_q) ? S_DONE : S_AR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    arvalid     = (state_q == S_AR);
    rready      = (state_q == S_R);
    ld_aw_valid = (state_q == S_WR) && !aw_done_q;
    ld_w_valid  = (state_q == S_WR) && !w_done_q;
    busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    done        = (state_q == S_DONE);
    araddr      = src_q + 64'(line_ofs_c);
    ld_aw_addr  = dst_q + RAM_AW'(line_ofs_c);
    ld_w_data   = buf_q;
    ld_w_strb   = '1;
    arid        = AR_ID;
    arlen       = 10'd0;
    arsize      = 3'b110;
    err         = err_q;
    lines_done  = lines_q;
    core_rst    = hold_q;
    load_en     = hold_q;
  end

  // Config latch, line buffer, progress and status
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      num_q     <= '0;
      lines_q   <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
      hold_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (accept_c) begin
      src_q     <= src_base;
      dst_q     <= dst_base;
      num_q     <= num_lines;
      lines_q   <= '0;
      err_q     <= 1'b0;
      hold_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      // release the core one cycle after reaching DONE
      if (state_q == S_DONE) hold_q <= 1'b0;
      if ((state_q == S_R) && rvalid) begin
        if (rresp != 2'b00) err_q <= 1'b1;
        else                buf_q <= rdata;
      end
      if (wr_fin_c) begin
        lines_q   <= lines_inc_c;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else if (state_q == S_WR) begin
        if (ld_aw_ready) aw_done_q <= 1'b1;
        if (ld_w_ready)  w_done_q  <= 1'b1;
      end
    end
  end

`ifdef PROG_LOADER_CKSUM_EN
  logic [31:0] fold_c;
  logic [31:0] cksum_q;

  // XOR of the 32-bit words of the buffered line
  always_comb begin
    fold_c = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      fold_c = fold_c ^ buf_q[i*32 +: 32];
    end
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n)  cksum_q <= '0;
    else if (accept_c)   cksum_q <= '0;
    else if (wr_fin_c)   cksum_q <= cksum_q ^ fold_c;
  end

  assign cksum = cksum_q;
`endif

endmodule
